// File: rtl/cpu_pkg.sv
// Shared types for the pipeline hazard controller: register width,
// shadow-pipeline entry layout and the controller action encoding.
package cpu_pkg;

  localparam int REG_W = 3;

  typedef struct packed {
    logic             valid;
    logic             wr;
    logic [REG_W-1:0] regd;
  } shadow_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

  localparam shadow_t SHADOW_NOP = '0;

endpackage

// File: rtl/hazard_match.sv
// One RAW comparator: a used source register against one in-flight
// shadow entry that will write its destination register.
import cpu_pkg::*;

module hazard_match (
  input  logic             i_use,
  input  logic [REG_W-1:0] i_src,
  input  logic             i_valid,
  input  logic             i_wr,
  input  logic [REG_W-1:0] i_regd,
  output logic             o_match
);

  assign o_match = i_use & i_valid & i_wr & (i_regd == i_src);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline. A shadow copy of ID/EX,
// EX/MEM and MEM/WB tracks pending register writes to detect RAW hazards.
import cpu_pkg::*;

module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             start_i,
  input  logic [REG_W-1:0] ifid_reg1_i,
  input  logic [REG_W-1:0] ifid_reg2_i,
  input  logic [REG_W-1:0] ifid_regD_i,
  input  logic             ifid_use1_i,
  input  logic             ifid_use2_i,
  input  logic             ifid_useD_i,
  input  logic             ifid_wr_i,
  input  logic             branch_i,
  output logic             stall_o,
  output logic             bubble_o,
  output logic             flush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  shadow_t          r_s0;
  shadow_t          r_s1;
  shadow_t          r_s2;
  logic             r_ifid_valid;
  hz_state_t        r_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  shadow_t          w_ent [3];
  logic [REG_W-1:0] w_src [3];
  logic             w_use [3];
  logic [8:0]       w_match;
  logic             w_hazard;
  logic             w_flush;
  logic             w_stall;
  logic             w_bubble;

  assign w_ent[0] = r_s0;
  assign w_ent[1] = r_s1;
  assign w_ent[2] = r_s2;

  assign w_src[0] = ifid_reg1_i;
  assign w_src[1] = ifid_reg2_i;
  assign w_src[2] = ifid_regD_i;

  assign w_use[0] = ifid_use1_i;
  assign w_use[1] = ifid_use2_i;
  assign w_use[2] = ifid_useD_i;

  // Comparator gi checks source gi%3 against shadow stage gi/3.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_match
      hazard_match u_match (
        .i_use   (w_use[gi % 3]),
        .i_src   (w_src[gi % 3]),
        .i_valid (w_ent[gi / 3].valid),
        .i_wr    (w_ent[gi / 3].wr),
        .i_regd  (w_ent[gi / 3].regd),
        .o_match (w_match[gi])
      );
    end
  endgenerate

  // start_i doubles as a flush so both pipeline registers fill with NOPs.
  assign w_flush  = start_i | (r_s0.valid & branch_i);
  assign w_hazard = r_ifid_valid & (|w_match);
  assign w_stall  = w_hazard & ~w_flush;
  assign w_bubble = w_stall | w_flush;

  assign stall_o     = w_stall;
  assign bubble_o    = w_bubble;
  assign flush_o     = w_flush;
  assign state_o     = r_state;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

  always_ff @(posedge clk) begin
    if (start_i) begin
      r_s0 <= SHADOW_NOP;
      r_s1 <= SHADOW_NOP;
      r_s2 <= SHADOW_NOP;
    end else begin
      r_s2 <= r_s1;
      r_s1 <= r_s0;
      r_s0 <= w_bubble ? SHADOW_NOP : {1'b1, ifid_wr_i, ifid_regD_i};
    end
  end

  // A stalled IF/ID keeps its contents; a flushed one holds a NOP.
  always_ff @(posedge clk) begin
    if (start_i || w_flush) begin
      r_ifid_valid <= 1'b0;
    end else if (!w_stall) begin
      r_ifid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      r_state <= RUN;
    end else if (w_flush) begin
      r_state <= FLUSH;
    end else if (w_stall) begin
      r_state <= STALL;
    end else begin
      r_state <= RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports, in order, each listed as name direction width meaning:
- clk  in  1  single clock.
- start_i  in  1  reset; synchronous, active-high.
- ifid_reg1_i  in  3  IF/ID source reg 1.
- ifid_reg2_i  in  3  IF/ID source reg 2.
- ifid_regD_i  in  3  IF/ID dest/third-source reg.
- ifid_use1_i  in  1  instr reads reg1.
- ifid_use2_i  in  1  instr reads reg2.
- ifid_useD_i  in  1  instr reads regD (store data/addr, jump target).
- ifid_wr_i  in  1  instr writes regD (control write_reg).
- branch_i  in  1  ALU branch-taken flag, EX stage.
REQ-002 SHALL have outputs, each listed as name direction width meaning:
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  load NOP (all write/read flags 0) into ID/EX.
- flush_o  out  1  load NOP into IF/ID; fetch takes branch target.
- state_o  out  2  RUN=0, STALL=1, FLUSH=2.
- stall_cnt_o  out  16  stall-cycle count, saturating.
- flush_cnt_o  out  16  flush count, saturating.
REQ-003 SHALL have one parameter: CNT_W, default 16, meaning counter width.
REQ-004 SHALL use one clock domain (clk) and reset start_i, which is synchronous and active-high.

Function
REQ-005 SHALL keep a 3-entry shadow pipeline S0/S1/S2 mirroring ID/EX, EX/MEM and MEM/WB, each entry {valid, wr, regD}.
REQ-006 SHALL keep an internal ifid_valid bit marking IF/ID as holding a real instruction.
REQ-007 Each clock edge, the shadow pipeline SHALL update as:
- S2<=S1; S1<=S0.
- S0<=bubble_o ? invalid : {1, ifid_wr_i, ifid_regD_i}.
REQ-008 SHALL compute flush_o = S0.valid & branch_i; a branch from a bubble is ignored.
REQ-009 SHALL compute hazard = ifid_valid & OR over used sources (use1/reg1, use2/reg2, useD/regD) of OR over k=0..2 of (Sk.valid & Sk.wr & Sk.regD==src).
REQ-010 Because the regfile has no write-through, an S2 match SHALL count as a hazard.
REQ-011 SHALL compute stall_o = hazard & ~flush_o; flush has priority over stall.
REQ-012 SHALL compute bubble_o = stall_o | flush_o.
REQ-013 ifid_valid SHALL update at each edge as: flush_o -> 0; else stall_o -> hold; else 1.
REQ-014 A RAW stall SHALL last at most 3 consecutive cycles (the producer exits S2).
REQ-015 stall_o, bubble_o and flush_o SHALL be combinational, with zero-cycle latency.
REQ-016 The state register SHALL load FLUSH if flush_o, else STALL if stall_o, else RUN; state_o reflects the previous cycle's action.
REQ-017 stall_cnt_o SHALL increment on each cycle with stall_o=1 and saturate at 0xFFFF.
REQ-018 flush_cnt_o SHALL increment on each cycle with flush_o=1 and saturate at 0xFFFF.
REQ-019 When a branch arrives while a stall is pending, SHALL output flush_o=1, stall_o=0, bubble_o=1, and discard the stalled instruction.

Reset
REQ-020 While start_i=1, SHALL force flush_o=1, bubble_o=1, stall_o=0 so that both pipeline registers fill with NOPs.
REQ-021 On an edge with start_i=1, SHALL set S0..S2 invalid, ifid_valid=0, state RUN and both counters 0.
REQ-022 A start_i asserted mid-stall or mid-flush SHALL override both, and SHALL NOT increment counters that cycle.
REQ-023 On the first edge after start_i falls, ifid_valid SHALL become 1.

Structure
REQ-024 Package cpu_pkg SHALL hold:
- REG_W=3.
- shadow-entry struct {valid, wr, regD}.
- hz_state_t enum {RUN, STALL, FLUSH}.
REQ-025 A sub-module hazard_match (one source vs one shadow entry -> match bit) SHALL be instantiated 9 times; all other logic SHALL be flat.
REQ-026 The implementation SHALL be 120-400 RTL lines, with no latches and a single clocked block per register group.

Verification
REQ-027 Reset test: hold start_i 2 cycles -> flush_o=1, bubble_o=1, stall_o=0, counters 0; after release, state_o=RUN.
REQ-028 Back-to-back RAW test: write r3 then read r3 (use1, reg1=3) -> stall_o=1 for exactly 3 cycles, then 0; stall_cnt_o=3.
REQ-029 Distance-2 test: write r5, one independent instr, then read r5 via useD -> stall_o=1 for 2 cycles.
REQ-030 Branch test: branch_i=1 with S0 valid -> flush_o=1 for 1 cycle, next state_o=FLUSH, flush_cnt_o=1; branch_i=1 with S0 invalid -> flush_o=0.
REQ-031 Priority test: branch_i=1 while a RAW stall is active -> stall_o=0, flush_o=1, and the following cycle has no stall.
REQ-032 Saturation test: force the counter to 0xFFFE, then stall 3 cycles -> stall_cnt_o=0xFFFF and it holds.
